// File: rtl/ooo_pkg.sv
// Shared out-of-order core sizing for branch checkpointing: checkpoint count,
// free-list pointer width and the derived tag type.
package ooo_pkg;
  localparam int NUM_CKPT   = 4;
  localparam int PTR_WIDTH  = 7;
  localparam int CKPT_IDX_W = $clog2(NUM_CKPT);

  typedef logic [CKPT_IDX_W-1:0] ckpt_tag_t;
endpackage

// File: rtl/ckpt_kill_mask.sv
// Combinational squash mask: marks every tag from start_tag up to tail-1,
// walking the checkpoint ring circularly.
module ckpt_kill_mask
  import ooo_pkg::*;
#(
  parameter int NUM_CKPT = ooo_pkg::NUM_CKPT,
  parameter int IDX_W    = $clog2(NUM_CKPT)
) (
  input  logic [IDX_W-1:0]    start_tag,
  input  logic [IDX_W-1:0]    tail,
  output logic [NUM_CKPT-1:0] mask
);

  logic [IDX_W-1:0] span;

  // A live start_tag with tail == start_tag means the ring wrapped fully,
  // so a zero span squashes everything.
  always_comb begin
    span = tail - start_tag;
    mask = '0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      mask[i] = (span == '0) || (IDX_W'(IDX_W'(i) - start_tag) < span);
    end
  end

endmodule

// File: rtl/branch_ckpt_ctrl.sv
// Branch checkpoint controller: allocates in-order checkpoint tags holding the
// free-list head pointer, frees them on resolve and restores on mispredict.
module branch_ckpt_ctrl
  import ooo_pkg::*;
#(
  parameter int NUM_CKPT  = ooo_pkg::NUM_CKPT,
  parameter int PTR_WIDTH = ooo_pkg::PTR_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          disp_valid,
  input  logic [PTR_WIDTH-1:0]          disp_head_ptr,
  output logic                          disp_ready,
  output logic [$clog2(NUM_CKPT)-1:0]   disp_tag,
  input  logic                          resolve_valid,
  input  logic [$clog2(NUM_CKPT)-1:0]   resolve_tag,
  input  logic                          resolve_mispredict,
  output logic                          restore_valid,
  output logic [PTR_WIDTH-1:0]          restore_head_ptr,
  output logic [NUM_CKPT-1:0]           kill_mask,
  output logic [$clog2(NUM_CKPT):0]     ckpt_count
);

  localparam int IDX_W = $clog2(NUM_CKPT);
  localparam int CNT_W = IDX_W + 1;

  logic [NUM_CKPT-1:0]  valid;
  logic [NUM_CKPT-1:0]  valid_next;
  logic [PTR_WIDTH-1:0] saved_ptr [NUM_CKPT];
  logic [IDX_W-1:0]     tail;
  logic [NUM_CKPT-1:0]  squash;
  logic                 mispredict;
  logic                 correct;
  logic                 accept;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_CKPT-1:0] bits);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CKPT; i++) n = n + CNT_W'(bits[i]);
    return n;
  endfunction

  // Resolves against a tag that is not live are ignored entirely.
  assign mispredict = resolve_valid && resolve_mispredict && valid[resolve_tag];
  assign correct    = resolve_valid && !resolve_mispredict && valid[resolve_tag];

  // Any mispredict request blocks dispatch, even one that turns out stale.
  assign disp_ready = !valid[tail] && !(resolve_valid && resolve_mispredict);
  assign disp_tag   = tail;
  assign accept     = disp_valid && disp_ready;
  assign ckpt_count = popcount(valid);

  ckpt_kill_mask #(
    .NUM_CKPT (NUM_CKPT),
    .IDX_W    (IDX_W)
  ) u_kill_mask (
    .start_tag (resolve_tag),
    .tail      (tail),
    .mask      (squash)
  );

  always_comb begin
    valid_next = valid;
    if (correct)    valid_next[resolve_tag] = 1'b0;
    if (accept)     valid_next[tail]        = 1'b1;
    if (mispredict) valid_next              = valid_next & ~squash;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid            <= '0;
      tail             <= '0;
      restore_valid    <= 1'b0;
      restore_head_ptr <= '0;
      kill_mask        <= '0;
    end else begin
      valid         <= valid_next;
      restore_valid <= mispredict;
      kill_mask     <= mispredict ? squash : '0;
      if (mispredict) begin
        tail             <= resolve_tag;
        restore_head_ptr <= saved_ptr[resolve_tag];
      end else if (accept) begin
        tail <= tail + 1'b1;
      end
    end
  end

  // Saved pointers are pure data; an entry's valid bit qualifies them.
  always_ff @(posedge clk) begin
    if (accept) saved_ptr[tail] <= disp_head_ptr;
  end

endmodule

// File: tb/tb_branch_ckpt_ctrl.sv
// Directed bench for branch_ckpt_ctrl: allocation, full stall, mispredict
// squash with wrap, same-cycle conflicts, stale resolves and mid-run reset.
module tb_branch_ckpt_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       disp_valid;
  logic [6:0] disp_head_ptr;
  logic       disp_ready;
  logic [1:0] disp_tag;
  logic       resolve_valid;
  logic [1:0] resolve_tag;
  logic       resolve_mispredict;
  logic       restore_valid;
  logic [6:0] restore_head_ptr;
  logic [3:0] kill_mask;
  logic [2:0] ckpt_count;

  int n_cmp = 0;
  int n_err = 0;

  branch_ckpt_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .disp_valid         (disp_valid),
    .disp_head_ptr      (disp_head_ptr),
    .disp_ready         (disp_ready),
    .disp_tag           (disp_tag),
    .resolve_valid      (resolve_valid),
    .resolve_tag        (resolve_tag),
    .resolve_mispredict (resolve_mispredict),
    .restore_valid      (restore_valid),
    .restore_head_ptr   (restore_head_ptr),
    .kill_mask          (kill_mask),
    .ckpt_count         (ckpt_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 0; resolve_valid = 0; resolve_mispredict = 0;
  endtask

  task automatic dispatch(input logic [6:0] ptr);
    disp_valid = 1; disp_head_ptr = ptr;
    tick();
    idle();
  endtask

  task automatic resolve(input logic [1:0] tag, input logic mp);
    resolve_valid = 1; resolve_tag = tag; resolve_mispredict = mp;
    tick();
    idle();
  endtask

  task automatic do_reset();
    reset = 1; idle(); disp_head_ptr = 0; resolve_tag = 0;
    tick(); tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (disp_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", disp_ready); end
    n_cmp++; if (disp_tag !== 2'd0) begin n_err++; $display("FAIL reset_tag got %0d want 0", disp_tag); end
    n_cmp++; if (ckpt_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", ckpt_count); end
    n_cmp++; if (restore_valid !== 1'b0) begin n_err++; $display("FAIL reset_restore got %0b want 0", restore_valid); end
    n_cmp++; if (kill_mask !== 4'b0000) begin n_err++; $display("FAIL reset_kill got %b want 0000", kill_mask); end
    n_cmp++; if (restore_head_ptr !== 7'd0) begin n_err++; $display("FAIL reset_rptr got %0d want 0", restore_head_ptr); end
  endtask

  task automatic test_dispatch();
    disp_valid = 1; disp_head_ptr = 7'd33;
    #1;
    n_cmp++; if (disp_tag !== 2'd0) begin n_err++; $display("FAIL disp_tag0 got %0d want 0", disp_tag); end
    n_cmp++; if (disp_ready !== 1'b1) begin n_err++; $display("FAIL disp_ready0 got %0b want 1", disp_ready); end
    tick(); idle();
    n_cmp++; if (ckpt_count !== 3'd1) begin n_err++; $display("FAIL disp_count got %0d want 1", ckpt_count); end
    n_cmp++; if (disp_tag !== 2'd1) begin n_err++; $display("FAIL disp_tail got %0d want 1", disp_tag); end
  endtask

  task automatic test_full();
    dispatch(7'd34); dispatch(7'd35); dispatch(7'd36);
    n_cmp++; if (ckpt_count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d want 4", ckpt_count); end
    n_cmp++; if (disp_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %0b want 0", disp_ready); end
    dispatch(7'd99);
    n_cmp++; if (ckpt_count !== 3'd4) begin n_err++; $display("FAIL full_fifth_count got %0d want 4", ckpt_count); end
    n_cmp++; if (disp_tag !== 2'd0) begin n_err++; $display("FAIL full_fifth_tag got %0d want 0", disp_tag); end
  endtask

  task automatic test_mispredict();
    resolve(2'd1, 1'b1);
    n_cmp++; if (restore_valid !== 1'b1) begin n_err++; $display("FAIL mp_restore got %0b want 1", restore_valid); end
    n_cmp++; if (restore_head_ptr !== 7'd34) begin n_err++; $display("FAIL mp_rptr got %0d want 34", restore_head_ptr); end
    n_cmp++; if (kill_mask !== 4'b1110) begin n_err++; $display("FAIL mp_kill got %b want 1110", kill_mask); end
    n_cmp++; if (ckpt_count !== 3'd1) begin n_err++; $display("FAIL mp_count got %0d want 1", ckpt_count); end
    n_cmp++; if (disp_tag !== 2'd1) begin n_err++; $display("FAIL mp_tail got %0d want 1", disp_tag); end
    tick();
    n_cmp++; if (restore_valid !== 1'b0) begin n_err++; $display("FAIL mp_pulse got %0b want 0", restore_valid); end
    n_cmp++; if (kill_mask !== 4'b0000) begin n_err++; $display("FAIL mp_kill_clr got %b want 0000", kill_mask); end
  endtask

  // Starts with tag 0 live and tail=1; builds live {3,0} with tail=1.
  task automatic test_wrap();
    disp_valid = 1; disp_head_ptr = 7'd41;
    resolve_valid = 1; resolve_tag = 2'd0; resolve_mispredict = 0;
    tick(); idle();
    n_cmp++; if (ckpt_count !== 3'd1) begin n_err++; $display("FAIL both_count got %0d want 1", ckpt_count); end
    n_cmp++; if (disp_tag !== 2'd2) begin n_err++; $display("FAIL both_tail got %0d want 2", disp_tag); end
    dispatch(7'd42); dispatch(7'd43); dispatch(7'd44);
    resolve(2'd1, 1'b0); resolve(2'd2, 1'b0);
    n_cmp++; if (ckpt_count !== 3'd2) begin n_err++; $display("FAIL wrap_pre_count got %0d want 2", ckpt_count); end
    resolve(2'd3, 1'b1);
    n_cmp++; if (kill_mask !== 4'b1001) begin n_err++; $display("FAIL wrap_kill got %b want 1001", kill_mask); end
    n_cmp++; if (disp_tag !== 2'd3) begin n_err++; $display("FAIL wrap_tail got %0d want 3", disp_tag); end
    n_cmp++; if (restore_head_ptr !== 7'd43) begin n_err++; $display("FAIL wrap_rptr got %0d want 43", restore_head_ptr); end
    n_cmp++; if (ckpt_count !== 3'd0) begin n_err++; $display("FAIL wrap_count got %0d want 0", ckpt_count); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    dispatch(7'd50);
    disp_valid = 1; disp_head_ptr = 7'd51;
    resolve_valid = 1; resolve_tag = 2'd0; resolve_mispredict = 1;
    #1;
    n_cmp++; if (disp_ready !== 1'b0) begin n_err++; $display("FAIL sc_ready got %0b want 0", disp_ready); end
    tick(); idle();
    n_cmp++; if (kill_mask !== 4'b0001) begin n_err++; $display("FAIL sc_kill got %b want 0001", kill_mask); end
    n_cmp++; if (ckpt_count !== 3'd0) begin n_err++; $display("FAIL sc_count got %0d want 0", ckpt_count); end
    n_cmp++; if (restore_head_ptr !== 7'd50) begin n_err++; $display("FAIL sc_rptr got %0d want 50", restore_head_ptr); end
    n_cmp++; if (disp_tag !== 2'd0) begin n_err++; $display("FAIL sc_tail got %0d want 0", disp_tag); end
  endtask

  task automatic test_free_twice();
    dispatch(7'd60); dispatch(7'd61); dispatch(7'd62); dispatch(7'd63);
    resolve_valid = 1; resolve_tag = 2'd2; resolve_mispredict = 0;
    #1;
    n_cmp++; if (disp_ready !== 1'b0) begin n_err++; $display("FAIL ft_ready_same got %0b want 0", disp_ready); end
    tick(); idle();
    n_cmp++; if (ckpt_count !== 3'd3) begin n_err++; $display("FAIL ft_count1 got %0d want 3", ckpt_count); end
    n_cmp++; if (disp_ready !== 1'b0) begin n_err++; $display("FAIL ft_ready1 got %0b want 0", disp_ready); end
    resolve(2'd2, 1'b0);
    n_cmp++; if (ckpt_count !== 3'd3) begin n_err++; $display("FAIL ft_count2 got %0d want 3", ckpt_count); end
    resolve(2'd2, 1'b1);
    n_cmp++; if (restore_valid !== 1'b0) begin n_err++; $display("FAIL ft_stale_mp got %0b want 0", restore_valid); end
    n_cmp++; if (ckpt_count !== 3'd3) begin n_err++; $display("FAIL ft_count3 got %0d want 3", ckpt_count); end
    resolve(2'd0, 1'b0);
    n_cmp++; if (disp_ready !== 1'b1) begin n_err++; $display("FAIL ft_ready2 got %0b want 1", disp_ready); end
    n_cmp++; if (ckpt_count !== 3'd2) begin n_err++; $display("FAIL ft_count4 got %0d want 2", ckpt_count); end
  endtask

  task automatic test_mid_reset();
    dispatch(7'd70);
    reset = 1; disp_valid = 1; disp_head_ptr = 7'd71;
    resolve_valid = 1; resolve_tag = 2'd1; resolve_mispredict = 1;
    tick();
    reset = 0; idle();
    n_cmp++; if (ckpt_count !== 3'd0) begin n_err++; $display("FAIL mr_count got %0d want 0", ckpt_count); end
    n_cmp++; if (restore_valid !== 1'b0) begin n_err++; $display("FAIL mr_restore got %0b want 0", restore_valid); end
    n_cmp++; if (disp_tag !== 2'd0) begin n_err++; $display("FAIL mr_tag got %0d want 0", disp_tag); end
    n_cmp++; if (kill_mask !== 4'b0000) begin n_err++; $display("FAIL mr_kill got %b want 0000", kill_mask); end
  endtask

  initial begin
    reset = 1; idle(); disp_head_ptr = 0; resolve_tag = 0;
    test_reset();
    test_dispatch();
    test_full();
    test_mispredict();
    test_wrap();
    test_same_cycle();
    test_free_twice();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
